// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states, default width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULDIV_MULTU = 2'b00,
    MULDIV_MULT  = 2'b01,
    MULDIV_DIVU  = 2'b10,
    MULDIV_DIV   = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == MULDIV_DIVU) || (op == MULDIV_DIV);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_e op);
    return (op == MULDIV_MULT) || (op == MULDIV_DIV);
  endfunction

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: y = neg ? -a : a. Used for operand
// magnitudes on launch and for sign correction of the finished result.
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (WIDTH iterations per op).
// Optional macro MULDIV_DIVZERO_FAST_EN: divide by zero skips CALC and finishes in two cycles.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic             res_neg_q;
  logic             rem_neg_q;
  logic             div_zero_q;
  logic [WIDTH-1:0] x_raw_q;
  logic [WIDTH-1:0] b_q;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] hi_acc_q;  // partial product high / partial remainder
  logic [WIDTH-1:0] lo_acc_q;  // multiplier bits / dividend-then-quotient bits

  muldiv_op_e       op_in;
  logic             x_neg;
  logic             y_neg;
  logic             y_zero;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;

  assign op_in  = muldiv_op_e'(Op);
  assign x_neg  = op_is_signed(op_in) & X[WIDTH-1];
  assign y_neg  = op_is_signed(op_in) & Y[WIDTH-1];
  assign y_zero = (Y == '0);

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_x (.a(X), .neg(x_neg), .y(x_mag));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_y (.a(Y), .neg(y_neg), .y(y_mag));

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    step_hi   = hi_acc_q;
    step_lo   = lo_acc_q;
    mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (is_div_q) begin
      if (div_shift >= {1'b0, b_q}) begin
        step_hi = div_diff;
        step_lo = {lo_acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction. A 2*WIDTH product negate only carries into the high
  // word when the low word is zero; otherwise the high word is just inverted.
  logic [WIDTH-1:0] lo_fix;
  logic [WIDTH-1:0] hi_neg;
  logic [WIDTH-1:0] hi_fix;

  muldiv_abs #(.WIDTH(WIDTH)) u_abs_lo (.a(lo_acc_q), .neg(res_neg_q), .y(lo_fix));
  muldiv_abs #(.WIDTH(WIDTH)) u_abs_hi (
    .a  (hi_acc_q),
    .neg(is_div_q ? rem_neg_q : res_neg_q),
    .y  (hi_neg)
  );

  assign hi_fix = (!is_div_q && res_neg_q && (lo_acc_q != '0)) ? ~hi_acc_q : hi_neg;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      x_raw_q    <= '0;
      b_q        <= '0;
      hi_acc_q   <= '0;
      lo_acc_q   <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      DivByZero  <= 1'b0;
      Hi         <= '0;
      Lo         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            is_div_q   <= op_is_div(op_in);
            res_neg_q  <= x_neg ^ y_neg;
            rem_neg_q  <= x_neg;
            div_zero_q <= op_is_div(op_in) && y_zero;
            x_raw_q    <= X;
            b_q        <= op_is_div(op_in) ? y_mag : x_mag;
            hi_acc_q   <= '0;
            lo_acc_q   <= op_is_div(op_in) ? x_mag : y_mag;
            cnt_q      <= '0;
            Busy       <= 1'b1;
`ifdef MULDIV_DIVZERO_FAST_EN
            state_q    <= (op_is_div(op_in) && y_zero) ? FIX : CALC;
`else
            state_q    <= CALC;
`endif
          end
        end
        CALC: begin
          hi_acc_q <= step_hi;
          lo_acc_q <= step_lo;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_q <= FIX;
        end
        FIX: begin
          state_q   <= IDLE;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          DivByZero <= div_zero_q;
          if (div_zero_q) begin
            Hi <= x_raw_q;
            Lo <= '1;
          end else begin
            Hi <= hi_fix;
            Lo <= lo_fix;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Direct MTHI/MTLO writes only while the unit is quiet; FIX always has Busy set.
      if (!Busy && !Done) begin
        if (HiWe) Hi <= WData;
        if (LoWe) Lo <= WData;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against an arithmetic model.
// Honours MULDIV_DIVZERO_FAST_EN for the expected divide-by-zero latency.
module tb_muldiv_unit;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t last_exp;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .Start    (start),
    .Op       (op),
    .X        (x),
    .Y        (y),
    .HiWe     (hi_we),
    .LoWe     (lo_we),
    .WData    (wdata),
    .Busy     (busy),
    .Done     (done),
    .DivByZero(div_by_zero),
    .Hi       (hi),
    .Lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 1'b0;
    p     = '0;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb);            e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
        end
      end
    endcase
    return e;
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] b);
`ifdef MULDIV_DIVZERO_FAST_EN
    if (o[1] && (b == '0)) return 2;
`endif
    return W + 2;
  endfunction

  // Launch one op; returns at #1 after the edge where Done rises.
  // we_cycle>0 pulses HiWe/LoWe while busy; b2b drives Start in the current (Done) cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int we_cycle, input bit b2b);
    exp_t e;
    int   done_at;
    int   busy_bad;
    e = model(o, a, b);
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start = 1'b1; op = o; x = a; y = b;
    done_at  = 0;
    busy_bad = 0;
    for (int n = 1; n <= 60 && done_at == 0; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      op    = 2'($urandom);
      x     = $urandom;
      y     = $urandom;
      hi_we = (n == we_cycle);
      lo_we = (n == we_cycle);
      wdata = $urandom;
      if (done) begin
        done_at = n;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
    end
    hi_we = 1'b0;
    lo_we = 1'b0;
    check({tag, ".latency"}, 64'(done_at), 64'(exp_latency(o, b)));
    check({tag, ".busy"},    64'(busy_bad), 64'd0);
    check({tag, ".hi"},      64'(hi), 64'(e.hi));
    check({tag, ".lo"},      64'(lo), 64'(e.lo));
    check({tag, ".dbz"},     64'(div_by_zero), 64'(e.dbz));
    last_exp = e;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; x = '0; y = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.dbz",  64'(div_by_zero), 64'd0);
    check("reset.hi",   64'(hi), 64'd0);
    check("reset.lo",   64'(lo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_max.hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    run_op("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7,         0, 1'b0);
    run_op("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         0, 1'b0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("div_ovf.lo_const", 64'(lo), 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'b10, 32'd100,       32'd0,         0, 1'b0);
    run_op("div_zero",  2'b11, 32'hFFFF_FF00, 32'd0,         0, 1'b1);
    run_op("divu_b2b",  2'b10, 32'd1000,      32'd7,         0, 1'b1);

    // A direct write in the Done cycle must be ignored.
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("done_cycle_we.hi", 64'(hi), 64'(last_exp.hi));

    // Reset mid-operation clears everything at once.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b00; x = 32'd5; y = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check("midreset.hi",   64'(hi), 64'd0);
    check("midreset.lo",   64'(lo), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("multu_we_busy", 2'b00, 32'd5, 32'd6, 5, 1'b0);

    @(posedge clk); #1;
    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi.hi", 64'(hi), 64'h0000_ABCD);
    check("mthi.lo", 64'(lo), 64'd30);
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo.lo", 64'(lo), 64'h1234_5678);
    check("mtlo.hi", 64'(hi), 64'h0000_ABCD);

    for (int i = 0; i < 24; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rand%0d", i), ro, ra, rb, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit with HI/LO result registers.
- Sits beside the ALU in the execute stage and shares its X/Y operand buses.
- Hi feeds ALU Result_2 slots 3/4 (MFHI/MFLO path); Lo feeds ALU Result slots 3/4.
- The pipeline controller stalls on Busy and resumes on Done.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- Clock  in  1  single system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  launch request; sampled only in IDLE.
- Op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start.
- X  in  WIDTH  multiplicand / dividend.
- Y  in  WIDTH  multiplier / divisor.
- HiWe  in  1  direct HI write (MTHI).
- LoWe  in  1  direct LO write (MTLO).
- WData  in  WIDTH  data for HiWe/LoWe.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle completion pulse.
- DivByZero  out  1  qualified by Done; Y was 0 on a divide.
- Hi  out  WIDTH  HI register: product high word / remainder.
- Lo  out  WIDTH  LO register: product low word / quotient.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0; iteration counter cleared. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: Start=1 at edge t latches |X|, |Y|, result sign, remainder sign, Op and zero-divisor flag; counter=0; -> CALC.
  - CALC: one shift-add (multiply) or restoring subtract-shift (divide) per cycle; after WIDTH cycles -> FIX.
  - FIX: apply sign correction, write Hi/Lo, Done=1 for one cycle; -> IDLE.
- Busy=1 from edge t+1 through the FIX cycle.
- Done and the new Hi/Lo values are visible after edge t+WIDTH+2 (t+34 at default).
- Signed ops: operands converted to magnitude first.
  - Product negated over 2*WIDTH bits when operand signs differ.
  - Quotient negated when signs differ; remainder takes the dividend's sign.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0, with no flag.
- Divide by zero: Hi=X (original dividend), Lo=all ones; DivByZero=1 alongside Done. Uses the full latency unless the optional feature is enabled.
- Start while Busy is ignored.
- Start in the cycle Done=1 is accepted, because the state is already IDLE.
- HiWe/LoWe:
  - Honoured only when not Busy and not Done.
  - Ignored otherwise.
  - If HiWe/LoWe and Start coincide in IDLE, both take effect; the write lands now and the result later overwrites it.
- Hi/Lo hold their values except on FIX or a direct write.
- Op changes after launch have no effect.

Optional Feature:
- MULDIV_DIVZERO_FAST_EN
  - Defined: a divide with Y==0 skips CALC (IDLE -> FIX); Done/DivByZero arrive after edge t+2. All other ops are unchanged.
  - Undefined: a divide by zero takes the full WIDTH+2 latency, with identical Hi/Lo/DivByZero values.

Decomposition:
- Package muldiv_pkg holds:
  - Op encodings MULDIV_MULTU/MULT/DIVU/DIV.
  - State enum IDLE/CALC/FIX.
  - Default WIDTH.
- Sub-module muldiv_abs: combinational conditional two's-complement negate of a WIDTH value. Used for operand magnitudes and result sign fix.

Test Plan:
- MULTU X=0xFFFFFFFF, Y=0xFFFFFFFF, Start at t -> Busy t+1..t+33; Done at t+34; Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT X=0xFFFFFFFD (-3), Y=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DivByZero=0.
- DIV X=0xFFFFFFF9 (-7), Y=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV X=0x80000000, Y=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU X=100, Y=0:
  - Macro off -> Done at t+34.
  - Macro on -> Done at t+2.
  - Both: DivByZero=1, Hi=0x64, Lo=0xFFFFFFFF.
- Start MULTU 5*6; assert Reset_n=0 at t+10 -> Busy/Done/Hi/Lo=0 immediately. Start again and HiWe pulse during Busy -> HiWe ignored, result Lo=30. Then HiWe with WData=0xABCD in IDLE -> Hi=0xABCD.
